vliw_lsu_arbiter: RTL and testbench
===================================

# vliw_lsu_arbiter

Load/store arbiter for the three-wide VLIW core. It captures the load/store requests produced by execution units 0–2 for one bundle and serializes them in slot order onto a single memory port. Load results are sign- or zero-extended and returned on one register-writeback port. A `busy` output stalls the core until the whole bundle has retired.

## Interface

Parameters:
- `REG_IDX_W`, default 6: width of a register index (64 registers).
- `NSLOT`, default 3: number of requesting execution units; fixed at 3 in this design.

Ports (clock and reset first):
- `wb_clk_i` in 1: the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue` in 1: one-cycle strobe; the bundle's requests are valid on this cycle.
- `is_load[2:0]`, `is_store[2:0]` in 3 each: per-slot request type. Both set on one slot means the store wins.
- `ls_addr0/1/2` in 32 each: byte address per slot.
- `ls_wdata0/1/2` in 32 each: store data per slot, right-aligned.
- `ls_size0/1/2` in 2 each: 0 = byte, 1 = half, 2 or 3 = word.
- `sign_extend[2:0]` in 3: per-slot load extension mode.
- `ls_dest0/1/2` in `REG_IDX_W` each: load destination register.
- `abort` in 1: drop every slot that has not started its memory access.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: store when 1, load when 0.
- `mem_addr` out 32.
- `mem_wdata` out 32.
- `mem_size` out 2.
- `mem_ack` in 1: access complete. Qualified by `mem_req`.
- `mem_rdata` in 32: load data, right-aligned; valid while `mem_ack` is high.
- `wb_valid` out 1: one-cycle register write.
- `wb_idx` out `REG_IDX_W`.
- `wb_data` out 32.
- `busy` out 1: bundle in progress.
- `overrun` out 1: sticky; cleared only by reset.

## Operation

- Registers per slot: `pend`, `we`, `addr`, `wdata`, `size`, `sext`, `dest`.
- On `issue` in IDLE:
  - `pend[i] = is_load[i] | is_store[i]`.
  - All other per-slot fields are latched.
  - If no slot is pending, nothing happens and `busy` stays 0.
- `issue` outside IDLE is ignored: the captured bundle is unchanged and `overrun` is set to 1.
- Service order is fixed: lowest pending slot first (0, then 1, then 2). This preserves intra-bundle program order.
- State IDLE:
  - On `issue` with any `pend`, go to ACCESS.
- State ACCESS:
  - Drive `mem_req=1` and the current slot's `we`, `addr`, `wdata`, `size`.
  - Inputs are held stable until `mem_ack`.
  - On `mem_ack` for a store: clear `pend[i]`. Go to ACCESS on the next pending slot if one remains, else IDLE.
  - On `mem_ack` for a load: capture the extended data, clear `pend[i]`, go to WB.
- State WB:
  - Drive `wb_valid=1`, `wb_idx=dest`, `wb_data=ext`.
  - Next state is ACCESS if any slot is pending, else IDLE.
- Store data masking, by size:
  - byte: `mem_wdata = {24'b0, wdata[7:0]}`.
  - half: `{16'b0, wdata[15:0]}`.
  - word: unchanged.
- Load extension, by size:
  - byte: `{{24{sext & rdata[7]}}, rdata[7:0]}`.
  - half: `{{16{sext & rdata[15]}}, rdata[15:0]}`.
  - word: unchanged.
- `abort`:
  - Clears every `pend` bit except the slot whose access is in flight (ACCESS with `mem_req` high).
  - That access completes normally, including its WB cycle if it is a load.
  - If `abort` and `mem_ack` arrive together, the in-flight slot still completes.
  - Aborting in IDLE has no effect.
- Reset: state IDLE and all `pend=0`.
- Outputs at reset: `mem_req`, `mem_we`, `wb_valid`, `busy`, `overrun` are 0; `mem_addr`, `mem_wdata`, `wb_data` are 0; `mem_size` and `wb_idx` are 0.
- Reset mid-access: `mem_req` drops immediately (asynchronously) and all pending slots are lost.

## Timing

- All outputs are registered or decoded from state; there is no combinational path from input to output.
- `issue` at cycle N → `busy=1` and `mem_req=1` (slot k) at N+1.
- Memory port latency is unbounded; `mem_req` stays high until `mem_ack`.
- Store `mem_ack` at cycle M:
  - More slots pending → the next slot's `mem_req` at M+1, with no bubble.
  - Last slot → `mem_req=0` and `busy=0` at M+1.
- Load `mem_ack` at cycle M:
  - `mem_req=0` and `wb_valid=1` at M+1.
  - The next slot's `mem_req` follows at M+2.
  - If this was the last slot, `busy=0` at M+2.
- Best case for 3 stores, each with 0-wait ack: `busy` is high for 3 cycles.
- Best case for 3 loads: `busy` is high for 6 cycles.
- `busy` is a pure state decode (`state != IDLE`). The core samples it to hold `issue` low.

## Test plan

- **Three word stores, 0-wait ack.**
  - Stimulus: slots 0/1/2 to addresses 0x100/0x104/0x108, data 0xA/0xB/0xC.
  - Required: three consecutive `mem_req` cycles in slot order with `mem_we=1`; `busy` high for exactly 3 cycles; no `wb_valid`.
- **Sign/zero extension.**
  - Stimulus: slot 0 byte load, `sext=1`, rdata 0x000000F0; slot 2 half load, `sext=0`, rdata 0xFFFF8001.
  - Required: `wb_data` 0xFFFFFFF0 (idx `ls_dest0`), then 0x00008001 (idx `ls_dest2`). Slot 1 is not accessed.
- **Mixed bundle with wait states.**
  - Stimulus: slot 0 load, slot 1 store byte with wdata 0x12345678; `mem_ack` delayed 3 cycles on each access.
  - Required: `mem_req` held for 4 cycles with stable address; store `mem_wdata` = 0x00000078; `wb_valid` precedes the store request.
- **Abort.**
  - Stimulus: 3 loads; `abort` during slot 0's wait state.
  - Required: slot 0 completes with one `wb_valid`; slots 1 and 2 are never requested; `busy` drops the cycle after that WB.
- **Overrun.**
  - Stimulus: second `issue` while `busy=1`.
  - Required: `overrun` goes to 1 and stays there; the captured bundle is unchanged; the access sequence is unchanged.
- **Reset mid-access and empty bundle.**
  - Stimulus: assert `rst_n=0` while `mem_req=1`.
  - Required: `mem_req`, `busy` and `overrun` go to 0 immediately.
  - Stimulus: after reset, `issue` with no loads or stores.
  - Required: `busy` stays 0.

Source files
------------

// File: rtl/vliw_lsu_arbiter.sv
// vliw_lsu_arbiter: captures one VLIW bundle's load/store slots and serializes them onto a single memory port.
module vliw_lsu_arbiter #(
    parameter int REG_IDX_W = 6,
    parameter int NSLOT     = 3
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    input  logic                 issue,
    input  logic [2:0]           is_load,
    input  logic [2:0]           is_store,
    input  logic [31:0]          ls_addr0,
    input  logic [31:0]          ls_addr1,
    input  logic [31:0]          ls_addr2,
    input  logic [31:0]          ls_wdata0,
    input  logic [31:0]          ls_wdata1,
    input  logic [31:0]          ls_wdata2,
    input  logic [1:0]           ls_size0,
    input  logic [1:0]           ls_size1,
    input  logic [1:0]           ls_size2,
    input  logic [2:0]           sign_extend,
    input  logic [REG_IDX_W-1:0] ls_dest0,
    input  logic [REG_IDX_W-1:0] ls_dest1,
    input  logic [REG_IDX_W-1:0] ls_dest2,
    input  logic                 abort,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [1:0]           mem_size,
    input  logic                 mem_ack,
    input  logic [31:0]          mem_rdata,
    output logic                 wb_valid,
    output logic [REG_IDX_W-1:0] wb_idx,
    output logic [31:0]          wb_data,
    output logic                 busy,
    output logic                 overrun
);
    typedef enum logic [1:0] {IDLE, ACCESS, WB} state_t;
    state_t state_q, state_d;
    logic [NSLOT-1:0]                pend_q, pend_d, we_q, we_d, sext_q, sext_d;
    logic [NSLOT-1:0][31:0]          addr_q, addr_d, wdata_q, wdata_d, in_addr, in_wdata;
    logic [NSLOT-1:0][1:0]           size_q, size_d, in_size;
    logic [NSLOT-1:0][REG_IDX_W-1:0] dest_q, dest_d, in_dest;
    logic [31:0]          ext_q, ext_d, ext, wmask;
    logic [REG_IDX_W-1:0] wbidx_q, wbidx_d;
    logic                 overrun_q, overrun_d;
    logic [1:0]           cur, sz;
    logic                 sx;

    assign in_addr  = {ls_addr2, ls_addr1, ls_addr0};
    assign in_wdata = {ls_wdata2, ls_wdata1, ls_wdata0};
    assign in_size  = {ls_size2, ls_size1, ls_size0};
    assign in_dest  = {ls_dest2, ls_dest1, ls_dest0};

    // Lowest pending slot is always the one in flight, preserving program order.
    assign cur   = pend_q[0] ? 2'd0 : pend_q[1] ? 2'd1 : 2'd2;
    assign sz    = size_q[cur];
    assign sx    = sext_q[cur];
    assign ext   = sz == 2'd0 ? {{24{sx & mem_rdata[7]}}, mem_rdata[7:0]} :
                   sz == 2'd1 ? {{16{sx & mem_rdata[15]}}, mem_rdata[15:0]} : mem_rdata;
    assign wmask = sz == 2'd0 ? {24'b0, wdata_q[cur][7:0]} :
                   sz == 2'd1 ? {16'b0, wdata_q[cur][15:0]} : wdata_q[cur];

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        we_d      = we_q;
        sext_d    = sext_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        dest_d    = dest_q;
        ext_d     = ext_q;
        wbidx_d   = wbidx_q;
        overrun_d = overrun_q | (issue & (state_q != IDLE));
        case (state_q)
            IDLE: if (issue) begin
                pend_d  = is_load | is_store;
                we_d    = is_store;
                sext_d  = sign_extend;
                addr_d  = in_addr;
                wdata_d = in_wdata;
                size_d  = in_size;
                dest_d  = in_dest;
                state_d = |(is_load | is_store) ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (abort) pend_d = pend_q & (3'b001 << cur);
                if (mem_ack) begin
                    pend_d[cur] = 1'b0;
                    if (we_q[cur]) begin
                        state_d = |pend_d ? ACCESS : IDLE;
                    end else begin
                        ext_d   = ext;
                        wbidx_d = dest_q[cur];
                        state_d = WB;
                    end
                end
            end
            WB: begin
                if (abort) pend_d = '0;
                state_d = |pend_d ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pend_q    <= '0;
            we_q      <= '0;
            sext_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= '0;
            dest_q    <= '0;
            ext_q     <= '0;
            wbidx_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            we_q      <= we_d;
            sext_q    <= sext_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            dest_q    <= dest_d;
            ext_q     <= ext_d;
            wbidx_q   <= wbidx_d;
            overrun_q <= overrun_d;
        end
    end

    assign mem_req   = state_q == ACCESS;
    assign mem_we    = mem_req & we_q[cur];
    assign mem_addr  = mem_req ? addr_q[cur] : '0;
    assign mem_wdata = mem_req ? wmask : '0;
    assign mem_size  = mem_req ? sz : '0;
    assign wb_valid  = state_q == WB;
    assign wb_idx    = wb_valid ? wbidx_q : '0;
    assign wb_data   = wb_valid ? ext_q : '0;
    assign busy      = state_q != IDLE;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_vliw_lsu_arbiter.sv
// tb_vliw_lsu_arbiter: directed bundles with a scoreboard of expected memory accesses and writebacks.
module tb_vliw_lsu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue, abort, mem_ack;
    logic [2:0]  is_load, is_store, sign_extend;
    logic [31:0] ls_addr0, ls_addr1, ls_addr2, ls_wdata0, ls_wdata1, ls_wdata2, mem_rdata;
    logic [1:0]  ls_size0, ls_size1, ls_size2;
    logic [5:0]  ls_dest0, ls_dest1, ls_dest2;
    logic        mem_req, mem_we, wb_valid, busy, overrun;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [1:0]  mem_size;
    logic [5:0]  wb_idx;

    typedef struct {
        bit          wb;
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        int          cyc;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] rd_q[$];
    int          vectors = 0, errs = 0, lat = 0, cnt = 0, busy_cnt = 0;

    always #5 clk = ~clk;

    vliw_lsu_arbiter dut (
        .wb_clk_i(clk), .rst_n(rst_n), .issue(issue), .is_load(is_load), .is_store(is_store),
        .ls_addr0(ls_addr0), .ls_addr1(ls_addr1), .ls_addr2(ls_addr2),
        .ls_wdata0(ls_wdata0), .ls_wdata1(ls_wdata1), .ls_wdata2(ls_wdata2),
        .ls_size0(ls_size0), .ls_size1(ls_size1), .ls_size2(ls_size2),
        .sign_extend(sign_extend), .ls_dest0(ls_dest0), .ls_dest1(ls_dest1), .ls_dest2(ls_dest2),
        .abort(abort), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data), .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", n, act, req);
        end
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] sz, input int cyc);
        exp_t e;
        e.wb = 1'b0; e.we = we; e.a = a; e.d = d; e.sz = sz; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic exp_wb(input logic [31:0] idx, input logic [31:0] d);
        exp_t e;
        e.wb = 1'b1; e.we = 1'b0; e.a = idx; e.d = d; e.sz = 2'd0; e.cyc = 0;
        sb.push_back(e);
    endtask

    // Memory responder and monitor: acks after lat wait cycles and checks each presented transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            cnt = 0;
            mem_ack = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (wb_valid) begin
                if (sb.size() == 0) chk("unexpected_wb", {26'b0, wb_idx}, 32'hFFFF_FFFF);
                else begin
                    e = sb.pop_front();
                    chk("wb_kind", 32'd1, {31'b0, e.wb});
                    chk("wb_idx", {26'b0, wb_idx}, e.a);
                    chk("wb_data", wb_data, e.d);
                end
            end
            mem_ack = 1'b0;
            if (mem_req) begin
                cnt++;
                if (cnt > lat) begin
                    mem_ack = 1'b1;
                    if (sb.size() == 0) chk("unexpected_req", mem_addr, 32'hFFFF_FFFF);
                    else begin
                        e = sb.pop_front();
                        chk("req_kind", 32'd0, {31'b0, e.wb});
                        chk("mem_we", {31'b0, mem_we}, {31'b0, e.we});
                        chk("mem_addr", mem_addr, e.a);
                        chk("mem_size", {30'b0, mem_size}, {30'b0, e.sz});
                        chk("req_cycles", cnt, e.cyc);
                        if (e.we) chk("mem_wdata", mem_wdata, e.d);
                        else mem_rdata = rd_q.size() != 0 ? rd_q.pop_front() : 32'h0;
                    end
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    task automatic do_issue();
        busy_cnt = 0;
        issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
    endtask

    task automatic finish_bundle(input string n, input int exp_busy);
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk({n, "_timeout"}, 32'd1, 32'd0);
        chk({n, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({n, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; issue = 1'b0; abort = 1'b0; is_load = '0; is_store = '0; sign_extend = '0;
        ls_addr0 = '0; ls_addr1 = '0; ls_addr2 = '0; ls_wdata0 = '0; ls_wdata1 = '0; ls_wdata2 = '0;
        ls_size0 = '0; ls_size1 = '0; ls_size2 = '0; ls_dest0 = '0; ls_dest1 = '0; ls_dest2 = '0;
        mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Three word stores, zero wait.
        lat = 0; is_store = 3'b111; is_load = 3'b000;
        ls_addr0 = 32'h100; ls_addr1 = 32'h104; ls_addr2 = 32'h108;
        ls_wdata0 = 32'hA; ls_wdata1 = 32'hB; ls_wdata2 = 32'hC;
        ls_size0 = 2'd2; ls_size1 = 2'd2; ls_size2 = 2'd2;
        exp_mem(1, 32'h100, 32'hA, 2, 1);
        exp_mem(1, 32'h104, 32'hB, 2, 1);
        exp_mem(1, 32'h108, 32'hC, 2, 1);
        do_issue();
        finish_bundle("stores", 3);

        // Sign/zero extension, slot 1 idle.
        is_store = 3'b000; is_load = 3'b101; sign_extend = 3'b001;
        ls_addr0 = 32'h200; ls_addr1 = 32'h300; ls_addr2 = 32'h204;
        ls_size0 = 2'd0; ls_size1 = 2'd2; ls_size2 = 2'd1;
        ls_dest0 = 6'd5; ls_dest1 = 6'd7; ls_dest2 = 6'd9;
        rd_q.push_back(32'h0000_00F0); rd_q.push_back(32'hFFFF_8001);
        exp_mem(0, 32'h200, 0, 0, 1); exp_wb(5, 32'hFFFF_FFF0);
        exp_mem(0, 32'h204, 0, 1, 1); exp_wb(9, 32'h0000_8001);
        do_issue();
        finish_bundle("ext", 4);

        // Mixed load/store with three wait states each.
        lat = 3; is_load = 3'b001; is_store = 3'b010; sign_extend = 3'b000;
        ls_addr0 = 32'h400; ls_addr1 = 32'h401; ls_size0 = 2'd2; ls_size1 = 2'd0;
        ls_wdata1 = 32'h1234_5678; ls_dest0 = 6'd3;
        rd_q.push_back(32'hCAFE_BABE);
        exp_mem(0, 32'h400, 0, 2, 4); exp_wb(3, 32'hCAFE_BABE);
        exp_mem(1, 32'h401, 32'h0000_0078, 0, 4);
        do_issue();
        finish_bundle("mixed", 9);

        // Abort during slot 0's wait: only slot 0 completes.
        is_load = 3'b111; is_store = 3'b000;
        ls_addr0 = 32'h600; ls_addr1 = 32'h604; ls_addr2 = 32'h608;
        ls_size0 = 2'd2; ls_size1 = 2'd2; ls_size2 = 2'd2; ls_dest0 = 6'd11;
        rd_q.push_back(32'h1357_9BDF);
        exp_mem(0, 32'h600, 0, 2, 4); exp_wb(11, 32'h1357_9BDF);
        do_issue();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        finish_bundle("abort", 5);
        chk("abort_no_overrun", {31'b0, overrun}, 32'd0);

        // Overrun: second issue while busy is ignored but flagged.
        lat = 1; is_load = 3'b000; is_store = 3'b011;
        ls_addr0 = 32'h500; ls_addr1 = 32'h504; ls_wdata0 = 32'h55; ls_wdata1 = 32'h66;
        ls_size0 = 2'd2; ls_size1 = 2'd2;
        exp_mem(1, 32'h500, 32'h55, 2, 2);
        exp_mem(1, 32'h504, 32'h66, 2, 2);
        do_issue();
        is_store = 3'b111; ls_addr0 = 32'h999; ls_wdata1 = 32'h77;
        issue = 1'b1;
        @(negedge clk);
        issue = 1'b0;
        chk("overrun_set", {31'b0, overrun}, 32'd1);
        finish_bundle("overrun", 4);
        chk("overrun_sticky", {31'b0, overrun}, 32'd1);

        // Reset mid-access, then an empty bundle.
        lat = 100; is_store = 3'b001; ls_addr0 = 32'h700;
        do_issue();
        @(negedge clk);
        chk("pre_rst_req", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, mem_req}, 32'd0);
        chk("async_rst_busy", {31'b0, busy}, 32'd0);
        chk("async_rst_overrun", {31'b0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0; is_store = 3'b000; is_load = 3'b000;
        do_issue();
        repeat (3) @(negedge clk);
        chk("empty_busy_cycles", busy_cnt, 32'd0);
        chk("empty_sb", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
